// File: rtl/cr_huf_comp_lut_mc.sv
// rtl/cr_huf_comp_lut_mc.sv - Double-banked Huffman code LUT with multi-channel single-cycle reads
module cr_huf_comp_lut_mc #(
  parameter int N_SYMBOLS   = 576,
  parameter int WORD_WIDTH  = 10,
  parameter int N_RD_CH     = 4,
  parameter int META_WIDTH  = 48,
  parameter int SEQID_WIDTH = 8,
  localparam int AW  = $clog2(N_SYMBOLS),
  localparam int PAW = AW - 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr,
  input  logic [PAW-1:0]                wr_addr,
  input  logic [2*WORD_WIDTH-1:0]       wr_data,
  input  logic [1:0]                    wr_val,
  input  logic                          wr_done,
  input  logic [SEQID_WIDTH-1:0]        wr_seq_id,
  input  logic                          wr_meta,
  input  logic [META_WIDTH-1:0]         wr_meta_data,
  output logic                          full,
  input  logic                          rd,
  input  logic [N_RD_CH*AW-1:0]         rd_addr,
  input  logic                          rd_done,
  input  logic [SEQID_WIDTH-1:0]        rd_seq_id,
  output logic [N_RD_CH*WORD_WIDTH-1:0] rd_data,
  output logic                          rd_val,
  output logic [META_WIDTH-1:0]         rd_meta_data,
  output logic                          rd_meta_vld,
  output logic                          err_ovf,
  output logic                          err_unf,
  output logic                          err_seq
);

  typedef enum logic [1:0] {EMPTY = 2'd0, FILL = 2'd1, READY = 2'd2} bank_state_t;

  localparam logic [AW:0] NSYM = (AW+1)'(N_SYMBOLS);

  // Table storage is not reset; only control state is.
  logic [WORD_WIDTH-1:0]  mem [2][N_SYMBOLS];
  bank_state_t            st [2];
  logic [1:0]             data_done;
  logic [1:0]             meta_done;
  logic [SEQID_WIDTH-1:0] seq_q [2];
  logic [META_WIDTH-1:0]  meta_q [2];
  logic                   wr_ptr;
  logic                   rd_ptr;

  logic                          rd_ready;
  logic                          wr_any;
  logic                          wr_ok;
  logic                          dd_nxt;
  logic                          md_nxt;
  logic [AW-1:0]                 ev_idx;
  logic [AW-1:0]                 od_idx;
  logic [AW-1:0]                 ra;
  logic [N_RD_CH*WORD_WIDTH-1:0] rd_word;

  assign full     = (st[wr_ptr] == READY);
  assign rd_ready = (st[rd_ptr] == READY);
  assign wr_any   = wr | wr_meta | wr_done;
  assign wr_ok    = wr_any & ~full;
  assign dd_nxt   = data_done[wr_ptr] | wr_done;
  assign md_nxt   = meta_done[wr_ptr] | wr_meta;
  assign ev_idx   = {wr_addr, 1'b0};
  assign od_idx   = {wr_addr, 1'b1};

  assign rd_meta_vld  = rd_ready;
  assign rd_meta_data = rd_ready ? meta_q[rd_ptr] : '0;

  // Per-channel lookup in the read bank; out-of-range addresses fall back to word 0.
  always_comb begin
    rd_word = '0;
    ra      = '0;
    for (int c = 0; c < N_RD_CH; c++) begin
      ra = rd_addr[c*AW +: AW];
      if ({1'b0, ra} >= NSYM) ra = '0;
      rd_word[c*WORD_WIDTH +: WORD_WIDTH] = mem[rd_ptr][ra];
    end
  end

  // Pair write into the write bank; each half gated by its own enable.
  always_ff @(posedge clk) begin
    if (wr && !full && ({1'b0, od_idx} < NSYM)) begin
      if (wr_val[0]) mem[wr_ptr][ev_idx] <= wr_data[WORD_WIDTH-1:0];
      if (wr_val[1]) mem[wr_ptr][od_idx] <= wr_data[2*WORD_WIDTH-1:WORD_WIDTH];
    end
  end

  // Bank state machines, pointers, read response and error pulses.
  // A completing write targets wr_ptr while a release targets rd_ptr; when the
  // pointers coincide the full/ready conditions make the two mutually exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < 2; b++) begin
        st[b]     <= EMPTY;
        seq_q[b]  <= '0;
        meta_q[b] <= '0;
      end
      data_done <= '0;
      meta_done <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      rd_data   <= '0;
      rd_val    <= 1'b0;
      err_ovf   <= 1'b0;
      err_unf   <= 1'b0;
      err_seq   <= 1'b0;
    end else begin
      err_ovf <= wr_any & full;
      err_unf <= (rd | rd_done) & ~rd_ready;
      err_seq <= rd & rd_ready & (rd_seq_id != seq_q[rd_ptr]);
      rd_val  <= rd & rd_ready;
      if (rd && rd_ready) rd_data <= rd_word;

      if (wr_ok) begin
        if (wr_meta) meta_q[wr_ptr] <= wr_meta_data;
        if (wr_done) seq_q[wr_ptr] <= wr_seq_id;
        if (dd_nxt && md_nxt) begin
          st[wr_ptr]        <= READY;
          data_done[wr_ptr] <= 1'b0;
          meta_done[wr_ptr] <= 1'b0;
          wr_ptr            <= ~wr_ptr;
        end else begin
          st[wr_ptr]        <= FILL;
          data_done[wr_ptr] <= dd_nxt;
          meta_done[wr_ptr] <= md_nxt;
        end
      end

      if (rd_done && rd_ready) begin
        st[rd_ptr] <= EMPTY;
        rd_ptr     <= ~rd_ptr;
      end
    end
  end

endmodule
